key_click_multi: RTL and testbench
==================================

// Module: key_click_multi
// PURPOSE
//  N-channel key front end: per-key 2-FF sync, press/release debounce with glitch
//  rejection, and classification into short, double and long click pulses.
//  Parametrised successor of the single-key short/long click block. Feeds LED/menu
//  control logic that consumes one-cycle event pulses and a debounced level.
// PARAMETERS
//  N_KEYS  4            number of independent key channels
//  T_DEB   500_000      debounce window in clocks (10 ms @ 50 MHz)
//  T_LONG  150_000_000  hold time for long click in clocks (3 s)
//  T_DBL   15_000_000   max gap release->2nd press for double click (300 ms)
//  DBL_EN  1            1: double-click detection on; 0: off (no WAIT2 state)
//  CW      28           counter width; must hold max(T_DEB,T_LONG,T_DBL)-1
// PORTS
//  CLOCK    in   1       system clock
//  RESET    in   1       synchronous, active-low reset
//  KEY      in   N_KEYS  raw keys, asynchronous, active-low (idle 1)
//  SCLICK   out  N_KEYS  one-cycle pulse per short click
//  DCLICK   out  N_KEYS  one-cycle pulse per double click
//  LCLICK   out  N_KEYS  one-cycle pulse per long click
//  PRESSED  out  N_KEYS  debounced pressed level (1 = held)
// BEHAVIOUR
//  Reset (RESET=0 at CLOCK edge): sync regs <=1, all FSMs IDLE, counters 0, all outputs 0.
//  Reset mid-operation: event in progress discarded, no pulse emitted.
//  Per channel: F1<=KEY, F2<=F1; H2L = F2&~F1, L2H = ~F2&F1; lvl = F1. Channels fully independent.
//  FSM (one counter C per channel, C cleared on every state change):
//   IDLE:     H2L -> DEB_DN.
//   DEB_DN:   count; at C==T_DEB-1: lvl==0 -> HELD, else IDLE (glitch, no event).
//   HELD:     L2H -> DEB_UP; else at C==T_LONG-1 -> pulse LCLICK, -> WAIT_REL. L2H wins on same cycle.
//   WAIT_REL: lvl==1 -> DEB_UP_X (release after long or 2nd press; no click).
//   DEB_UP:   at C==T_DEB-1 -> DBL_EN ? WAIT2 : (pulse SCLICK, IDLE).
//   DEB_UP_X: at C==T_DEB-1 -> IDLE.
//   WAIT2:    H2L -> DEB_DN2; else at C==T_DBL-1 -> pulse SCLICK, -> IDLE.
//   DEB_DN2:  at C==T_DEB-1: lvl==0 -> pulse DCLICK, -> WAIT_REL; else pulse SCLICK, -> IDLE.
//  Input edges ignored during DEB_* states (debounce blanking).
//  PRESSED=1 in HELD, WAIT_REL; 0 elsewhere. Registered outputs; pulses exactly 1 cycle.
//  At most one of SCLICK/DCLICK/LCLICK per channel per gesture; never two in one cycle.
//  Latency (KEY edge -> event, clocks): sync adds 2. Long: 2+T_DEB+T_LONG after press.
//   Short, DBL_EN=0: 2+T_DEB after release. Short, DBL_EN=1: 2+T_DEB+T_DBL after release.
//   Double: 2+T_DEB after 2nd press edge.
//  Counter compares are equality on CW bits; C never wraps (every state exits at its limit).
// TESTING (bench: N_KEYS=2, T_DEB=4, T_LONG=40, T_DBL=20)
//  1 KEY[0] low 10 clk then high -> one SCLICK[0] pulse, 2+4+20 clk after release; no D/L pulse.
//  2 KEY[0] low 10, high 8, low 10, high -> one DCLICK[0] ~6 clk after 2nd press; no SCLICK[0].
//  3 KEY[1] low 60 clk -> LCLICK[1] at 46 clk after press; PRESSED[1]=1 until release debounced; no SCLICK.
//  4 KEY[0] low 2 clk glitch -> FSM returns IDLE, no pulses, PRESSED[0] stays 0; repeat with DBL_EN=0:
//    10-clk press -> SCLICK[0] 6 clk after release.
//  5 KEY[0] short press and KEY[1] long press overlapped -> independent SCLICK[0] and LCLICK[1], correct timing.
//  6 RESET=0 for 1 clk while KEY[0] in HELD -> all outputs 0 next clk, no pulse on later release.

Source files
------------

// File: rtl/key_click_multi.sv
// key_click_multi: per-key sync, debounce and short/double/long click classification.
module key_click_multi #(
    parameter int N_KEYS = 4,
    parameter int T_DEB  = 500_000,
    parameter int T_LONG = 150_000_000,
    parameter int T_DBL  = 15_000_000,
    parameter int DBL_EN = 1,
    parameter int CW     = 28
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] SCLICK,
    output logic [N_KEYS-1:0] DCLICK,
    output logic [N_KEYS-1:0] LCLICK,
    output logic [N_KEYS-1:0] PRESSED
);
    localparam logic [CW-1:0] debLast  = CW'(T_DEB - 1);
    localparam logic [CW-1:0] longLast = CW'(T_LONG - 1);
    localparam logic [CW-1:0] dblLast  = CW'(T_DBL - 1);

    typedef enum logic [2:0] {IDLE, DEB_DN, HELD, WAIT_REL, DEB_UP, DEB_UP_X, WAIT2, DEB_DN2} stateT;

    for (genvar k = 0; k < N_KEYS; k++) begin : gKey
        logic f1, f2, sClick, dClick, lClick, pressed;
        logic [CW-1:0] cnt;
        stateT state;
        wire h2l = f2 & ~f1;
        wire l2h = ~f2 & f1;
        wire lvl = f1;
        // every branch that changes state also clears cnt; IDLE/WAIT_REL hold it at 0
        always_ff @(posedge CLOCK) begin
            if (!RESET) begin
                f1      <= 1'b1;
                f2      <= 1'b1;
                state   <= IDLE;
                cnt     <= '0;
                sClick  <= 1'b0;
                dClick  <= 1'b0;
                lClick  <= 1'b0;
                pressed <= 1'b0;
            end else begin
                f1     <= KEY[k];
                f2     <= f1;
                sClick <= 1'b0;
                dClick <= 1'b0;
                lClick <= 1'b0;
                cnt    <= cnt + 1'b1;
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (h2l) state <= DEB_DN;
                    end
                    DEB_DN: if (cnt == debLast) begin
                        cnt     <= '0;
                        state   <= lvl ? IDLE : HELD;
                        pressed <= ~lvl;
                    end
                    HELD: if (l2h) begin
                        cnt     <= '0;
                        state   <= DEB_UP;
                        pressed <= 1'b0;
                    end else if (cnt == longLast) begin
                        cnt    <= '0;
                        lClick <= 1'b1;
                        state  <= WAIT_REL;
                    end
                    WAIT_REL: begin
                        cnt <= '0;
                        if (lvl) begin
                            state   <= DEB_UP_X;
                            pressed <= 1'b0;
                        end
                    end
                    DEB_UP: if (cnt == debLast) begin
                        cnt    <= '0;
                        state  <= (DBL_EN != 0) ? WAIT2 : IDLE;
                        sClick <= (DBL_EN == 0);
                    end
                    DEB_UP_X: if (cnt == debLast) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                    WAIT2: if (h2l) begin
                        cnt   <= '0;
                        state <= DEB_DN2;
                    end else if (cnt == dblLast) begin
                        cnt    <= '0;
                        sClick <= 1'b1;
                        state  <= IDLE;
                    end
                    DEB_DN2: if (cnt == debLast) begin
                        cnt     <= '0;
                        dClick  <= ~lvl;
                        sClick  <= lvl;
                        pressed <= ~lvl;
                        state   <= lvl ? IDLE : WAIT_REL;
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
        assign SCLICK[k]  = sClick;
        assign DCLICK[k]  = dClick;
        assign LCLICK[k]  = lClick;
        assign PRESSED[k] = pressed;
    end
endmodule

// File: tb/tb_key_click_multi.sv
// tb_key_click_multi: directed click gestures against hand-computed pulse counts and cycles.
module tb_key_click_multi;
    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    logic [1:0] KEY = 2'b11;
    logic [1:0] SCLICK, DCLICK, LCLICK, PRESSED;
    logic [1:0] sClick0, dClick0, lClick0, pressed0;
    int vecCount = 0, errCount = 0, cyc = 0, multiCnt = 0;
    int sCnt[2] = '{0, 0}, dCnt[2] = '{0, 0}, lCnt[2] = '{0, 0}, pHi[2] = '{0, 0};
    int sAt[2] = '{-1, -1}, dAt[2] = '{-1, -1}, lAt[2] = '{-1, -1};
    int s0Cnt = 0, d0Cnt = 0, l0Cnt = 0, s0At = -1;
    int sBase[2], dBase[2], lBase[2], pBase[2], s0Base, d0Base, l0Base;
    int p, r, p1;

    key_click_multi #(.N_KEYS(2), .T_DEB(4), .T_LONG(40), .T_DBL(20), .DBL_EN(1), .CW(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .KEY(KEY),
        .SCLICK(SCLICK), .DCLICK(DCLICK), .LCLICK(LCLICK), .PRESSED(PRESSED)
    );
    key_click_multi #(.N_KEYS(2), .T_DEB(4), .T_LONG(40), .T_DBL(20), .DBL_EN(0), .CW(8)) dut0 (
        .CLOCK(CLOCK), .RESET(RESET), .KEY(KEY),
        .SCLICK(sClick0), .DCLICK(dClick0), .LCLICK(lClick0), .PRESSED(pressed0)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(negedge CLOCK) begin
        for (int k = 0; k < 2; k++) begin
            if (SCLICK[k] === 1'b1) begin sCnt[k]++; sAt[k] = cyc; end
            if (DCLICK[k] === 1'b1) begin dCnt[k]++; dAt[k] = cyc; end
            if (LCLICK[k] === 1'b1) begin lCnt[k]++; lAt[k] = cyc; end
            if (PRESSED[k] === 1'b1) pHi[k]++;
            if (int'(SCLICK[k]) + int'(DCLICK[k]) + int'(LCLICK[k]) > 1) multiCnt++;
        end
        if (sClick0[0] === 1'b1) begin s0Cnt++; s0At = cyc; end
        if (dClick0[0] === 1'b1) d0Cnt++;
        if (lClick0[0] === 1'b1) l0Cnt++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic snap();
        sBase = sCnt; dBase = dCnt; lBase = lCnt; pBase = pHi;
        s0Base = s0Cnt; d0Base = d0Cnt; l0Base = l0Cnt;
    endtask

    initial begin
        clocks(2);
        checkVal("reset outs", {SCLICK, DCLICK, LCLICK, PRESSED}, 0);
        checkVal("reset outs dbl off", {sClick0, dClick0, lClick0, pressed0}, 0);
        RESET = 1'b1;
        clocks(5);
        // short click, DBL_EN=1
        snap(); KEY[0] = 1'b0; clocks(10);
        checkVal("t1 pressed held", PRESSED[0], 1);
        KEY[0] = 1'b1; r = cyc; clocks(40);
        checkVal("t1 sclick count", sCnt[0] - sBase[0], 1);
        checkVal("t1 sclick cycle", sAt[0], r + 26);
        checkVal("t1 no dclick", dCnt[0] - dBase[0], 0);
        checkVal("t1 no lclick", lCnt[0] - lBase[0], 0);
        checkVal("t1 pressed released", PRESSED[0], 0);
        // double click
        snap(); KEY[0] = 1'b0; clocks(10); KEY[0] = 1'b1; clocks(8);
        KEY[0] = 1'b0; p = cyc; clocks(10); KEY[0] = 1'b1; clocks(40);
        checkVal("t2 dclick count", dCnt[0] - dBase[0], 1);
        checkVal("t2 dclick cycle", dAt[0], p + 6);
        checkVal("t2 no sclick", sCnt[0] - sBase[0], 0);
        checkVal("t2 no lclick", lCnt[0] - lBase[0], 0);
        // long click on key 1
        snap(); KEY[1] = 1'b0; p = cyc; clocks(30);
        checkVal("t3 pressed mid hold", PRESSED[1], 1);
        clocks(30);
        checkVal("t3 lclick count", lCnt[1] - lBase[1], 1);
        checkVal("t3 lclick cycle", lAt[1], p + 46);
        checkVal("t3 pressed wait rel", PRESSED[1], 1);
        KEY[1] = 1'b1; clocks(1);
        checkVal("t3 pressed before sync", PRESSED[1], 1);
        clocks(2);
        checkVal("t3 pressed after release", PRESSED[1], 0);
        clocks(40);
        checkVal("t3 no sclick", sCnt[1] - sBase[1], 0);
        checkVal("t3 no dclick", dCnt[1] - dBase[1], 0);
        // glitch rejection, then DBL_EN=0 short click
        snap(); KEY[0] = 1'b0; clocks(2); KEY[0] = 1'b1; clocks(40);
        checkVal("t4 glitch pulses", (sCnt[0] - sBase[0]) + (dCnt[0] - dBase[0]) + (lCnt[0] - lBase[0]), 0);
        checkVal("t4 glitch pressed", pHi[0] - pBase[0], 0);
        checkVal("t4 glitch pulses dbl off", (s0Cnt - s0Base) + (d0Cnt - d0Base) + (l0Cnt - l0Base), 0);
        snap(); KEY[0] = 1'b0; clocks(10); KEY[0] = 1'b1; r = cyc; clocks(40);
        checkVal("t4 dbl off sclick count", s0Cnt - s0Base, 1);
        checkVal("t4 dbl off sclick cycle", s0At, r + 6);
        checkVal("t4 dbl off no l/d", (d0Cnt - d0Base) + (l0Cnt - l0Base), 0);
        // overlapped short on key 0 and long on key 1
        snap(); KEY[0] = 1'b0; clocks(3); KEY[1] = 1'b0; p1 = cyc; clocks(7);
        KEY[0] = 1'b1; r = cyc; clocks(43); KEY[1] = 1'b1; clocks(40);
        checkVal("t5 sclick0 count", sCnt[0] - sBase[0], 1);
        checkVal("t5 sclick0 cycle", sAt[0], r + 26);
        checkVal("t5 lclick1 count", lCnt[1] - lBase[1], 1);
        checkVal("t5 lclick1 cycle", lAt[1], p1 + 46);
        checkVal("t5 other pulses", (lCnt[0] - lBase[0]) + (sCnt[1] - sBase[1]) + (dCnt[0] - dBase[0]) + (dCnt[1] - dBase[1]), 0);
        // reset while key 0 is held
        KEY[0] = 1'b0; clocks(8);
        checkVal("t6 pressed before reset", PRESSED[0], 1);
        RESET = 1'b0; clocks(1);
        checkVal("t6 outs in reset", {SCLICK, DCLICK, LCLICK, PRESSED}, 0);
        RESET = 1'b1; snap(); clocks(2); KEY[0] = 1'b1; clocks(40);
        checkVal("t6 no pulse after reset", (sCnt[0] - sBase[0]) + (dCnt[0] - dBase[0]) + (lCnt[0] - lBase[0]), 0);
        checkVal("t6 pressed after reset", pHi[0] - pBase[0], 0);
        checkVal("one pulse per cycle", multiCnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end
endmodule
